wb_fifo_tx: RTL and testbench

WB_FIFO_TX -- requirements
Module: wb_fifo_tx

---
 rtl/wb_fifo_tx_pkg.sv | 33 +++
 rtl/if_wb.sv | 20 ++
 rtl/wb_fifo_tx_fifo_sync.sv | 74 +++++++
 rtl/wb_fifo_tx.sv | 86 ++++++++
 tb/tb_wb_fifo_tx.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_fifo_tx_pkg.sv
// Shared register map and bit positions for the Wishbone-fed transmit FIFO.
package wb_fifo_tx_pkg;

  typedef enum logic [1:0] {
    REG_DATA     = 2'd0,
    REG_STATUS   = 2'd1,
    REG_CONTROL  = 2'd2,
    REG_RESERVED = 2'd3
  } reg_sel_e;

  localparam int ADR_REG_LSB = 1;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;

  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  // Count occupies the upper byte; every bit not named above reads as zero.
  function automatic logic [15:0] packStatus(input logic empty, input logic full,
                                             input logic ovf, input logic [7:0] count);
    logic [15:0] status;
    status = '0;
    status[STATUS_EMPTY_BIT] = empty;
    status[STATUS_FULL_BIT]  = full;
    status[STATUS_OVF_BIT]   = ovf;
    status[STATUS_COUNT_LSB +: 8] = count;
    return status;
  endfunction

endpackage

// File: rtl/if_wb.sv
// Classic single-clock Wishbone bus bundle including its clock and reset.
interface if_wb #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input logic clk,
  input logic rst
);
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_i;
  logic [DW-1:0]   dat_o;
  logic            we;
  logic [DW/8-1:0] sel;
  logic            stb;
  logic            cyc;
  logic            ack;

  modport slave (input clk, rst, adr, dat_i, we, sel, stb, cyc, output dat_o, ack);
  modport master (input clk, rst, dat_o, ack, output adr, dat_i, we, sel, stb, cyc);
endinterface

// File: rtl/wb_fifo_tx_fifo_sync.sv
// Synchronous circular FIFO with flush; head word is presented combinationally.
module fifo_sync #(
  parameter int  DEPTH = 16,
  parameter int  DW    = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          doPush;
  logic          doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem[rdPtr_q];

  // Fullness is judged before any same-cycle pop, so a push into a full FIFO is lost.
  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && doPush) begin
      mem[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/wb_fifo_tx.sv
// Wishbone slave front end feeding a transmit FIFO drained by a valid/ready consumer.
module wb_fifo_tx #(
  parameter int DEPTH = 16,
  parameter int DW    = 16
) (
  if_wb.slave           wb,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready
);
  import wb_fifo_tx_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          ack_q, ack_d;
  logic [DW-1:0] datO_q, datO_d;
  logic          ovf_q, ovf_d;

  reg_sel_e      regSel;
  logic          request;
  logic          accessDone;
  logic          wrData;
  logic          wrCtrl;
  logic          fifoFlush;
  logic          clrOvf;
  logic          fifoPop;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [CW-1:0] fifoCount;
  logic          unused_bus;

  assign regSel     = reg_sel_e'(wb.adr[ADR_REG_LSB +: 2]);
  assign request    = wb.cyc && wb.stb && !ack_q;
  // Side effects land only in the ack cycle, so a reset between request and ack aborts cleanly.
  assign accessDone = ack_q && wb.cyc && wb.stb;
  assign wrData     = accessDone && wb.we && (regSel == REG_DATA);
  assign wrCtrl     = accessDone && wb.we && (regSel == REG_CONTROL);
  assign fifoFlush  = wrCtrl && wb.dat_i[CTRL_FLUSH_BIT];
  assign clrOvf     = wrCtrl && wb.dat_i[CTRL_CLR_OVF_BIT];
  assign fifoPop    = !fifoEmpty && m_ready;
  assign m_valid    = !fifoEmpty;
  assign unused_bus = ^{wb.sel, wb.adr};

  assign wb.ack   = ack_q;
  assign wb.dat_o = datO_q;

  fifo_sync #(
    .DEPTH(DEPTH),
    .DW   (DW)
  ) u_fifo (
    .clk_i  (wb.clk),
    .rst_i  (wb.rst),
    .push_i (wrData),
    .data_i (wb.dat_i),
    .pop_i  (fifoPop),
    .flush_i(fifoFlush),
    .data_o (m_data),
    .full_o (fifoFull),
    .empty_o(fifoEmpty),
    .count_o(fifoCount)
  );

  always_comb begin
    ack_d  = request;
    datO_d = '0;
    ovf_d  = ovf_q;
    if (request && !wb.we && (regSel == REG_STATUS)) begin
      datO_d[15:0] = packStatus(fifoEmpty, fifoFull, ovf_q, 8'(fifoCount));
    end
    if (wrData && fifoFull) ovf_d = 1'b1;
    if (clrOvf)             ovf_d = 1'b0;
  end

  always_ff @(posedge wb.clk) begin
    if (wb.rst) begin
      ack_q  <= 1'b0;
      datO_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      datO_q <= datO_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_wb_fifo_tx.sv
// Scenario bench for wb_fifo_tx: bus accesses plus a scoreboard on the consumer side.
`timescale 1ns/1ps
module tb_wb_fifo_tx;
  import wb_fifo_tx_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_wb #(.DW(DW), .AW(8)) wbBus (.clk(clk), .rst(rst));

  logic [DW-1:0] mData;
  logic          mValid;
  logic          mReady;

  wb_fifo_tx #(.DEPTH(DEPTH), .DW(DW)) dut (
    .wb     (wbBus),
    .m_data (mData),
    .m_valid(mValid),
    .m_ready(mReady)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] expQ[$];
  logic          validAtAck;
  logic [DW-1:0] rd;

  // Consumer-side scoreboard: a handshake seen mid-cycle retires at the next rising edge.
  always @(negedge clk) begin
    if (!rst && mValid && mReady) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL popUnexpected: got m_data=%h, required no valid data", mData);
      end else begin
        if (mData !== expQ[0]) begin
          errors++;
          $display("[TB] FAIL popData: got m_data=%h, required %h", mData, expQ[0]);
        end
        void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic busAccess(input logic wr, input logic [1:0] regIdx,
                           input logic [DW-1:0] wdata, output logic [DW-1:0] rdata);
    wbBus.adr   = {5'b0, regIdx, 1'b0};
    wbBus.we    = wr;
    wbBus.dat_i = wdata;
    wbBus.sel   = '1;
    wbBus.cyc   = 1'b1;
    wbBus.stb   = 1'b1;
    cycle();
    checks++;
    if (wbBus.ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ackLatency: ack=%b, required 1", wbBus.ack);
    end
    rdata      = wbBus.dat_o;
    validAtAck = mValid;
    cycle();
    wbBus.cyc = 1'b0;
    wbBus.stb = 1'b0;
    wbBus.we  = 1'b0;
    checks++;
    if (wbBus.ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ackWidth: ack=%b, required 0", wbBus.ack);
    end
  endtask

  task automatic busWrite(input logic [1:0] regIdx, input logic [DW-1:0] wdata);
    logic [DW-1:0] dummy;
    busAccess(1'b1, regIdx, wdata, dummy);
  endtask

  task automatic busRead(input logic [1:0] regIdx, output logic [DW-1:0] rdata);
    busAccess(1'b0, regIdx, '0, rdata);
  endtask

  task automatic checkStatus(input string tag, input logic [DW-1:0] expected);
    logic [DW-1:0] st;
    busRead(REG_STATUS, st);
    checks++;
    if (st !== expected) begin
      errors++;
      $display("[TB] FAIL %s: STATUS=%h, required %h", tag, st, expected);
    end
  endtask

  task automatic drainAll();
    int n = 0;
    mReady = 1'b1;
    while (expQ.size() != 0 && n < 200) begin
      cycle();
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drainTimeout: %0d words left, required 0", expQ.size());
    end
    checks++;
    if (mValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drainEmpty: m_valid=%b, required 0", mValid);
    end
    mReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    checks++;
    if (wbBus.ack !== 1'b0 || wbBus.dat_o !== '0 || mValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL resetState: ack=%b dat_o=%h m_valid=%b, required 0/0000/0",
               wbBus.ack, wbBus.dat_o, mValid);
    end
    rst = 1'b0;
    cycle();
    checkStatus("resetStatus", 16'h0001);
  endtask

  task automatic test_single_write();
    expQ.push_back(16'h1234);
    busWrite(REG_DATA, 16'h1234);
    checks++;
    if (validAtAck !== 1'b0) begin
      errors++;
      $display("[TB] FAIL validDuringAck: m_valid=%b, required 0", validAtAck);
    end
    checks++;
    if (mValid !== 1'b1 || mData !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL validAfterAck: m_valid=%b m_data=%h, required 1/1234", mValid, mData);
    end
    repeat (2) cycle();
    checks++;
    if (mValid !== 1'b1 || mData !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL holdStable: m_valid=%b m_data=%h, required 1/1234", mValid, mData);
    end
    checkStatus("singleStatus", 16'h0100);
    drainAll();
  endtask

  task automatic test_register_reads();
    expQ.push_back(16'h7777);
    busWrite(REG_DATA, 16'h7777);
    busRead(REG_DATA, rd);
    checks++;
    if (rd !== '0) begin
      errors++;
      $display("[TB] FAIL readData: got %h, required 0000", rd);
    end
    busRead(REG_CONTROL, rd);
    checks++;
    if (rd !== '0) begin
      errors++;
      $display("[TB] FAIL readControl: got %h, required 0000", rd);
    end
    busRead(REG_RESERVED, rd);
    checks++;
    if (rd !== '0) begin
      errors++;
      $display("[TB] FAIL readReserved: got %h, required 0000", rd);
    end
    busWrite(REG_RESERVED, 16'hFFFF);
    checkStatus("reservedWrite", 16'h0100);
    wbBus.adr = {5'b0, 2'(REG_STATUS), 1'b0};
    wbBus.stb = 1'b1;
    wbBus.cyc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (wbBus.ack !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stbWithoutCyc: ack=%b, required 0", wbBus.ack);
      end
    end
    wbBus.stb = 1'b0;
    drainAll();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      expQ.push_back(DW'(i));
      busWrite(REG_DATA, DW'(i));
    end
    busWrite(REG_DATA, 16'hBEEF);
    checkStatus("fullOverflow", 16'h1006);
    drainAll();
    checkStatus("overflowSticky", 16'h0005);
  endtask

  task automatic test_full_pop();
    busWrite(REG_CONTROL, 16'h0002);
    checkStatus("overflowCleared", 16'h0001);
    for (int i = 0; i < 16; i++) begin
      expQ.push_back(16'hA000 + DW'(i));
      busWrite(REG_DATA, 16'hA000 + DW'(i));
    end
    wbBus.adr   = {5'b0, 2'(REG_DATA), 1'b0};
    wbBus.we    = 1'b1;
    wbBus.dat_i = 16'hDEAD;
    wbBus.cyc   = 1'b1;
    wbBus.stb   = 1'b1;
    cycle();
    checks++;
    if (wbBus.ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fullPopAck: ack=%b, required 1", wbBus.ack);
    end
    mReady = 1'b1;
    cycle();
    mReady    = 1'b0;
    wbBus.cyc = 1'b0;
    wbBus.stb = 1'b0;
    wbBus.we  = 1'b0;
    checkStatus("fullPopStatus", 16'h0F04);
    busWrite(REG_CONTROL, 16'h0002);
    checkStatus("clearOverflow", 16'h0F00);
    drainAll();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      expQ.push_back(16'h5000 + DW'(i));
      busWrite(REG_DATA, 16'h5000 + DW'(i));
    end
    mReady = 1'b1;
    busWrite(REG_CONTROL, 16'h0001);
    mReady = 1'b0;
    expQ.delete();
    checks++;
    if (mValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flushValid: m_valid=%b, required 0", mValid);
    end
    checkStatus("flushStatus", 16'h0001);
  endtask

  task automatic test_back_to_back();
    mReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      expQ.push_back(16'hC000 + DW'(i * 3));
      busWrite(REG_DATA, 16'hC000 + DW'(i * 3));
    end
    drainAll();
    checkStatus("wrapStatus", 16'h0001);
  endtask

  task automatic test_reset_mid_op();
    for (int i = 0; i < 2; i++) begin
      busWrite(REG_DATA, 16'h3300 + DW'(i));
    end
    checks++;
    if (mValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prefill: m_valid=%b, required 1", mValid);
    end
    wbBus.adr   = {5'b0, 2'(REG_DATA), 1'b0};
    wbBus.we    = 1'b1;
    wbBus.dat_i = 16'h5555;
    wbBus.cyc   = 1'b1;
    wbBus.stb   = 1'b1;
    rst         = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (wbBus.ack !== 1'b0 || mValid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL resetMidOp: ack=%b m_valid=%b, required 0/0", wbBus.ack, mValid);
      end
    end
    rst       = 1'b0;
    wbBus.cyc = 1'b0;
    wbBus.stb = 1'b0;
    wbBus.we  = 1'b0;
    cycle();
    checks++;
    if (wbBus.ack !== 1'b0 || mValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL afterAbort: ack=%b m_valid=%b, required 0/0", wbBus.ack, mValid);
    end
    checkStatus("abortStatus", 16'h0001);
  endtask

  initial begin
    wbBus.adr   = '0;
    wbBus.dat_i = '0;
    wbBus.we    = 1'b0;
    wbBus.sel   = '0;
    wbBus.stb   = 1'b0;
    wbBus.cyc   = 1'b0;
    mReady      = 1'b0;
    validAtAck  = 1'b0;
    test_reset();
    test_single_write();
    test_register_reads();
    test_overflow();
    test_full_pop();
    test_flush();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
